pixel_read_ctrl: RTL and testbench
==================================

# pixel_read_ctrl

Readout controller that sits directly downstream of the pixel priority-encoder tree. It drives the tree's `ReadCLK`, samples the tree's `valid` and `addrOut` on every step, and stores each hit address tagged with a frame number in an internal FIFO. It presents stored hits to the periphery over a valid/ready stream. One `Start` drains all pending pixels of one frame. Each `ReadCLK` rising edge clears the currently encoded pixel, and the next-priority pixel then appears on the tree outputs.

## Interface
- `ADDR_WID`, 5: width of the tree address input.
- `FID_WID`, 8: frame-id width.
- `CNT_WID`, 10: hit-counter width.
- `DEPTH`, 8: FIFO depth in entries; must be a power of two, ≥2.
- `CLK_HALF`, 2: `ReadCLK` high time, and the low/settle time, in `CLK` cycles; ≥1.

Ports:
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RSTn` in 1: asynchronous, active-low reset.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `Start` in 1: request readout of one frame; sampled only in IDLE.
- `Busy` out 1: high in every state except IDLE.
- `Done` out 1: one-cycle pulse at the end of a frame.
- `ReadCLK` out 1: registered step clock to the tree root.
- `valid` in 1: tree root valid (combinational from the tree).
- `addrIn` in `ADDR_WID`: tree root address.
- `DataOut` out `FID_WID+ADDR_WID`: FIFO head, formatted as {frame id, address}.
- `DataValid` out 1: FIFO non-empty.
- `DataReady` in 1: consumer accepts the head when `DataValid` is high.
- `HitCount` out `CNT_WID`: hits stored in the current or last frame; saturates at all-ones.
- `FrameId` out `FID_WID`: id of the current or last frame.

## Operation
- State machine states: IDLE, SETTLE, SAMPLE, PULSE, DONE.
- IDLE:
  - On `Start`=1, go to SETTLE.
  - `FrameId` increments, wrapping from all-ones to 0.
  - `HitCount` clears to 0.
  - `Start` in any other state is ignored; it is not queued.
- SETTLE:
  - `ReadCLK`=0 for exactly `CLK_HALF` cycles, which lets the tree propagate.
  - Then go to SAMPLE.
- SAMPLE lasts one cycle, with `ReadCLK`=0:
  - `valid`=0: go to DONE.
  - `valid`=1 and FIFO not full:
    - Push {`FrameId`, `addrIn`}.
    - `HitCount`+1, saturating.
    - Go to PULSE.
  - `valid`=1 and FIFO full: stay in SAMPLE. This is a stall with no pulse, so no hit is lost; it re-evaluates every cycle.
- PULSE: `ReadCLK`=1 for exactly `CLK_HALF` cycles, then go to SETTLE.
- DONE: `Done`=1 for one cycle, `Busy`=1, then go to IDLE.
- FIFO:
  - Push is allowed only if the occupancy at the start of the cycle is < `DEPTH`. A pop in the same cycle does not free a slot for that cycle's push.
  - Pop occurs when `DataValid`&`DataReady`.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
  - `DataOut` is the head entry, with first-word fall-through.
  - `DataOut` is don't-care when `DataValid`=0.
- The FIFO continues to drain in IDLE. Entries from successive frames stay in order.
- Reset values:
  - State IDLE.
  - `ReadCLK`=0, `Busy`=0, `Done`=0.
  - `DataValid`=0; FIFO empty.
  - `HitCount`=0; `FrameId`=0, so the first frame gets id 1.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously), including `ReadCLK` if it is mid-pulse.
  - FIFO contents are discarded.

## Timing
- `Start` is sampled at edge 0. `Busy`=1 from cycle 1.
- SETTLE occupies cycles 1..`CLK_HALF`. SAMPLE is cycle `CLK_HALF`+1.
- A push at a SAMPLE edge makes `DataValid`=1 in the next cycle if the FIFO was empty.
- Throughput without stall: one hit per `2*CLK_HALF+1` cycles.
- `ReadCLK` is registered: high exactly `CLK_HALF` cycles, low at least `CLK_HALF`+1 cycles between pulses, and glitch-free.
- `valid` and `addrIn` are used combinationally in SAMPLE only. They must be stable by the end of the settle interval.
- Frame with zero hits: `Done` high in cycle `CLK_HALF`+2, `Busy`=0 from cycle `CLK_HALF`+3.
- Frame with N hits and no stalls: `Done` in cycle (N+1)(`2*CLK_HALF`+1)+1−`CLK_HALF`.

## Test plan
Bench tree model: a queue of pending addresses. The model drives `valid`=1 and `addrIn`=head while the queue is non-empty, and pops on each `ReadCLK` rise.
- Empty tree, `CLK_HALF`=2, `Start` at edge 0:
  - `Done` is high in cycle 4 only; `Busy`=0 in cycle 5.
  - `ReadCLK` never rises; `HitCount`=0; `FrameId`=1.
- One hit, address 19, `DataReady`=1:
  - `DataValid` in cycle 4 with `DataOut`={8'd1,5'd19}.
  - `ReadCLK` is high in cycles 4–5.
  - `Done` in cycle 9; `HitCount`=1.
- 12 hits, addresses 0..11, `DataReady`=0, `DEPTH`=8:
  - After 8 pulses the block stalls in SAMPLE with `ReadCLK`=0 and `Busy`=1.
  - Raising `DataReady` resumes pulsing.
  - Output is 0..11 in order; `HitCount`=12; no loss and no duplicates.
- `Start` re-pulsed while `Busy`: ignored, with `FrameId` unchanged.
- 256 back-to-back frames: `FrameId` wraps 255→0.
- `RSTn` dropped while `ReadCLK`=1 with 3 entries queued:
  - `ReadCLK`, `DataValid` and `Busy` go to 0 without waiting for a clock edge.
  - After release, the next `Start` yields `FrameId`=1.

Source files
------------

// File: rtl/pixel_read_ctrl.sv
// Generic synchronous FIFO with first-word fall-through read data.
// Latency: a write is visible on rd_dat/rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy drops at DEPTH entries; a same-cycle read does not reopen it.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    // Fullness is judged on the occupancy at the start of the cycle only.
    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Steps the pixel priority tree with ReadCLK and queues {frame id, address} hits.
// Latency: one hit per 2*CLK_HALF+1 cycles; a hit reaches DataOut the cycle after SAMPLE.
// Backpressure: with the FIFO full the FSM holds in SAMPLE without pulsing, so no hit is lost.
module pixel_read_ctrl #(
    parameter int ADDR_WID = 5,
    parameter int FID_WID  = 8,
    parameter int CNT_WID  = 10,
    parameter int DEPTH    = 8,
    parameter int CLK_HALF = 2
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic                        Start,
    output logic                        Busy,
    output logic                        Done,
    output logic                        ReadCLK,
    input  logic                        valid,
    input  logic [ADDR_WID-1:0]         addrIn,
    output logic [FID_WID+ADDR_WID-1:0] DataOut,
    output logic                        DataValid,
    input  logic                        DataReady,
    output logic [CNT_WID-1:0]          HitCount,
    output logic [FID_WID-1:0]          FrameId
);
    localparam int DW = FID_WID + ADDR_WID;
    localparam int CW = $clog2(CLK_HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_PULSE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               read_clk;
    logic               busy;
    logic               done;
    logic [FID_WID-1:0] frame_id;
    logic [CNT_WID-1:0] hit_count;
    logic               fifo_rdy;
    logic               push;

    // The tree outputs are only trusted in SAMPLE, after the settle interval.
    assign push = (state == S_SAMPLE) && valid && fifo_rdy;

    fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk (CLK),
        .arst_n   (RSTn),
        .wr_vld   (push),
        .wr_rdy   (fifo_rdy),
        .wr_dat   ({frame_id, addrIn}),
        .rd_vld   (DataValid),
        .rd_rdy   (DataReady),
        .rd_dat   (DataOut)
    );

    // Readout sequencer; ReadCLK, Busy and Done are registered so they never glitch.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            read_clk  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_id  <= '0;
            hit_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state     <= S_SETTLE;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        frame_id  <= frame_id + 1'b1;
                        hit_count <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (!valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (fifo_rdy) begin
                        state    <= S_PULSE;
                        read_clk <= 1'b1;
                        cnt      <= '0;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 1'b1;
                        end
                    end
                end
                S_PULSE: begin
                    if (cnt == LAST) begin
                        state    <= S_SETTLE;
                        read_clk <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ReadCLK  = read_clk;
    assign Busy     = busy;
    assign Done     = done;
    assign FrameId  = frame_id;
    assign HitCount = hit_count;
endmodule

// File: tb/tb_pixel_read_ctrl.sv
// Bench for pixel_read_ctrl: queue-based tree model, scoreboard of expected hits,
// per-cycle checks of stream data, Done contents and ReadCLK pulse shape,
// plus directed frames with hand-computed cycle numbers.
module tb_pixel_read_ctrl;
    localparam int AW  = 5;
    localparam int FW  = 8;
    localparam int CWD = 10;
    localparam int DEP = 8;
    localparam int CH  = 2;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          Start = 1'b0;
    logic          DataReady = 1'b0;
    logic          Busy;
    logic          Done;
    logic          ReadCLK;
    logic          valid;
    logic [AW-1:0] addrIn;
    logic [FW+AW-1:0] DataOut;
    logic          DataValid;
    logic [CWD-1:0] HitCount;
    logic [FW-1:0] FrameId;

    pixel_read_ctrl #(
        .ADDR_WID (AW),
        .FID_WID  (FW),
        .CNT_WID  (CWD),
        .DEPTH    (DEP),
        .CLK_HALF (CH)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .ReadCLK   (ReadCLK),
        .valid     (valid),
        .addrIn    (addrIn),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .HitCount  (HitCount),
        .FrameId   (FrameId)
    );

    always #5 CLK = ~CLK;

    // Tree model: pending addresses in a ring, head presented while non-empty.
    logic [AW-1:0] tree_addr [256];
    int tree_wr  = 0;
    int tree_rd  = 0;
    int rise_cnt = 0;
    assign valid  = (tree_rd != tree_wr);
    assign addrIn = tree_addr[tree_rd[7:0]];

    always @(posedge ReadCLK) begin
        tree_rd  = tree_rd + 1;
        rise_cnt = rise_cnt + 1;
    end

    // Scoreboard / model state.
    logic [FW+AW-1:0] exp_q [$];
    logic [FW-1:0]    fid_m = '0;
    int exp_hits = 0;
    int n_chk    = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Per-cycle compare against the model.
    int   hi_run = 0;
    int   lo_run = 100;
    logic rclk_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RSTn) begin
            hi_run    = 0;
            lo_run    = 100;
            rclk_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (DataValid && DataReady) begin
                if (exp_q.size() == 0) begin
                    chk("pop_with_model_empty", {31'd0, DataValid}, 32'd0);
                end else begin
                    chk("data_out", {19'd0, DataOut}, {19'd0, exp_q.pop_front()});
                    pop_cnt++;
                end
            end
            if (Done) begin
                chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
                chk("done_hit_count", {22'd0, HitCount}, exp_hits);
                chk("done_frame_id", {24'd0, FrameId}, {24'd0, fid_m});
            end
            if (ReadCLK && !rclk_prev) begin
                chk("readclk_low_time", {31'd0, (lo_run >= CH + 1)}, 32'd1);
                hi_run = 1;
            end else if (ReadCLK) begin
                hi_run++;
            end
            if (!ReadCLK && rclk_prev) begin
                chk("readclk_high_time", hi_run, CH);
                lo_run = 1;
            end else if (!ReadCLK) begin
                lo_run++;
            end
            rclk_prev = ReadCLK;
            done_prev = Done;
        end
    end

    task automatic load(input logic [AW-1:0] a);
        tree_addr[tree_wr[7:0]] = a;
        tree_wr++;
    endtask

    // Start at the next edge (edge 0); model learns the frame's hits from the tree.
    task automatic start_frame();
        @(negedge CLK);
        Start = 1'b1;
        fid_m = fid_m + 1'b1;
        exp_hits = tree_wr - tree_rd;
        for (int i = tree_rd; i < tree_wr; i++) begin
            exp_q.push_back({fid_m, tree_addr[i[7:0]]});
        end
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge CLK);
            if (Done) seen = 1'b1;
        end
        chk("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    // Cycle k is the period ending at edge k; cycle 1 directly follows the Start edge.
    logic             tr_busy [32];
    logic             tr_done [32];
    logic             tr_rclk [32];
    logic             tr_dv   [32];
    logic [FW+AW-1:0] tr_dout [32];

    task automatic trace(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            tr_busy[c] = Busy;
            tr_done[c] = Done;
            tr_rclk[c] = ReadCLK;
            tr_dv[c]   = DataValid;
            tr_dout[c] = DataOut;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd;
        int nd;
        int any_rclk;
        int base;
        int pbase;
        logic [FW+AW-1:0] e_word;

        // Reset state.
        @(negedge CLK);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_readclk", {31'd0, ReadCLK}, 32'd0);
        chk("rst_datavalid", {31'd0, DataValid}, 32'd0);
        chk("rst_hitcount", {22'd0, HitCount}, 32'd0);
        chk("rst_frameid", {24'd0, FrameId}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        idle(2);

        // One hit at address 19, consumer always ready.
        DataReady = 1'b1;
        load(5'd19);
        start_frame();
        trace(12);
        e_word = {8'd1, 5'd19};
        chk("hit1_dv_c3", {31'd0, tr_dv[3]}, 32'd0);
        chk("hit1_dv_c4", {31'd0, tr_dv[4]}, 32'd1);
        chk("hit1_dout_c4", {19'd0, tr_dout[4]}, {19'd0, e_word});
        chk("hit1_rclk_c3", {31'd0, tr_rclk[3]}, 32'd0);
        chk("hit1_rclk_c4", {31'd0, tr_rclk[4]}, 32'd1);
        chk("hit1_rclk_c5", {31'd0, tr_rclk[5]}, 32'd1);
        chk("hit1_rclk_c6", {31'd0, tr_rclk[6]}, 32'd0);
        fd = -1;
        nd = 0;
        for (int c = 1; c <= 12; c++) begin
            if (tr_done[c]) begin
                nd++;
                if (fd < 0) fd = c;
            end
        end
        chk("hit1_done_cycle", fd, 32'd9);
        chk("hit1_done_count", nd, 32'd1);
        chk("hit1_hitcount", {22'd0, HitCount}, 32'd1);

        // Empty tree.
        start_frame();
        trace(8);
        fd = -1;
        nd = 0;
        any_rclk = 0;
        for (int c = 1; c <= 8; c++) begin
            if (tr_done[c]) begin
                nd++;
                if (fd < 0) fd = c;
            end
            if (tr_rclk[c]) any_rclk++;
        end
        chk("empty_done_cycle", fd, 32'd4);
        chk("empty_done_count", nd, 32'd1);
        chk("empty_busy_c1", {31'd0, tr_busy[1]}, 32'd1);
        chk("empty_busy_c4", {31'd0, tr_busy[4]}, 32'd1);
        chk("empty_busy_c5", {31'd0, tr_busy[5]}, 32'd0);
        chk("empty_no_readclk", any_rclk, 32'd0);
        chk("empty_hitcount", {22'd0, HitCount}, 32'd0);
        chk("empty_frameid", {24'd0, FrameId}, 32'd2);

        // 12 hits into an 8-deep FIFO with the consumer stalled.
        DataReady = 1'b0;
        for (int a = 0; a < 12; a++) load(a[AW-1:0]);
        base  = rise_cnt;
        pbase = pop_cnt;
        start_frame();
        for (int c = 0; c < 200 && rise_cnt != base + 8; c++) @(negedge CLK);
        idle(30);
        chk("stall_pulses", rise_cnt - base, 32'd8);
        chk("stall_readclk", {31'd0, ReadCLK}, 32'd0);
        chk("stall_busy", {31'd0, Busy}, 32'd1);
        chk("stall_datavalid", {31'd0, DataValid}, 32'd1);
        DataReady = 1'b1;
        wait_done(400);
        chk("full_hitcount", {22'd0, HitCount}, 32'd12);
        chk("full_pulses", rise_cnt - base, 32'd12);
        idle(20);
        chk("full_popped", pop_cnt - pbase, 32'd12);
        chk("full_model_drained", exp_q.size(), 32'd0);

        // Start re-pulsed mid-frame is ignored and not queued.
        load(5'd7);
        load(5'd30);
        start_frame();
        idle(4);
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(200);
        idle(3);
        chk("restart_busy_low", {31'd0, Busy}, 32'd0);
        chk("restart_frameid", {24'd0, FrameId}, 32'd4);

        // Back-to-back empty frames until the frame id wraps.
        while (fid_m != 8'd255) begin
            start_frame();
            wait_done(50);
        end
        chk("wrap_frameid_255", {24'd0, FrameId}, 32'd255);
        start_frame();
        chk("wrap_frameid_0", {24'd0, FrameId}, 32'd0);
        wait_done(50);
        idle(3);

        // Asynchronous reset while ReadCLK is high with 3 entries queued.
        DataReady = 1'b0;
        for (int a = 20; a < 25; a++) load(a[AW-1:0]);
        base = rise_cnt;
        start_frame();
        for (int c = 0; c < 200 && rise_cnt != base + 3; c++) @(negedge CLK);
        chk("arst_pre_readclk", {31'd0, ReadCLK}, 32'd1);
        chk("arst_pre_datavalid", {31'd0, DataValid}, 32'd1);
        #1;
        RSTn = 1'b0;
        #1;
        chk("arst_readclk", {31'd0, ReadCLK}, 32'd0);
        chk("arst_datavalid", {31'd0, DataValid}, 32'd0);
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_frameid", {24'd0, FrameId}, 32'd0);
        exp_q.delete();
        fid_m = '0;
        exp_hits = 0;
        idle(2);
        RSTn = 1'b1;
        DataReady = 1'b1;
        start_frame();
        chk("post_rst_frameid", {24'd0, FrameId}, 32'd1);
        wait_done(100);
        idle(10);
        chk("post_rst_model_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
